dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and the 32-bit-block data memory.
- Consumes the READ, WRITE and address/data signals driven by the control unit and datapath.
- Returns READDATA and BUSYWAIT; the CPU's HOLD derives from BUSYWAIT.
- Drives the block-wide memory interface.

Parameters:
- INDEX_W, 3, index bits; number of lines = 2**INDEX_W.
- Fixed widths: 8-bit byte address, 4-byte blocks (offset = ADDRESS[1:0]), TAG_W = 6 - INDEX_W.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  byte address.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  stall request to the CPU.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  write-back block.
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Address split: tag = ADDRESS[7:2+INDEX_W], index = ADDRESS[1+INDEX_W:2], offset = ADDRESS[1:0].
- Byte k of a block sits at bits [8k+7:8k].
- Per line: valid, dirty, tag, 32-bit data.
- hit = valid[index] & (tag[index] == tag).
- Reset (RESET low, asynchronous):
  - state = IDLE; all valid and dirty bits cleared.
  - MEM_READ = MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0, BUSYWAIT = 0, READDATA = 0.
  - Data and tag arrays need not be cleared.
- READ and WRITE both high is illegal; the request is treated as READ.
- READDATA: combinational selected byte of the indexed line; valid when READ & hit in IDLE.
- BUSYWAIT (combinational) = (READ|WRITE) & ~(state==IDLE & hit).
- Load hit: 0 stall cycles; READDATA valid in the same cycle.
- Store hit: byte written at the next posedge and dirty set; BUSYWAIT stays low.
- States: IDLE, WRITEBACK, FETCH.
- IDLE:
  - Request that misses with the indexed line valid & dirty -> WRITEBACK.
  - Request that misses otherwise -> FETCH.
  - No request or hit -> IDLE.
- WRITEBACK:
  - Outputs: MEM_WRITE = 1, MEM_ADDRESS = {stored tag, index}, MEM_WRITEDATA = line data.
  - On a posedge with MEM_BUSYWAIT low -> FETCH.
- FETCH:
  - Outputs: MEM_READ = 1, MEM_ADDRESS = ADDRESS[7:2].
  - On a posedge with MEM_BUSYWAIT low: install MEM_READDATA, set the tag, valid = 1, dirty = 0 -> IDLE.
  - The request then hits in the following cycle and completes normally: a store sets dirty there.
- Memory contract:
  - Memory asserts MEM_BUSYWAIT combinationally in the same cycle MEM_READ or MEM_WRITE rises.
  - Memory holds MEM_BUSYWAIT until the data is done.
  - The controller never asserts MEM_READ and MEM_WRITE together.
- CPU contract:
  - The CPU holds READ, WRITE, ADDRESS and WRITEDATA stable while BUSYWAIT is high.
  - The controller latches nothing from the CPU.
- Reset mid-transfer: return to IDLE immediately, drop MEM_READ/MEM_WRITE, invalidate all lines; the partial transfer is discarded.
- Miss latency:
  - Clean miss: 1 cycle (IDLE→FETCH) + memory latency, then the hit cycle.
  - Dirty miss: additionally the write-back memory latency.

Decomposition:
- Package dcache_pkg holds:
  - state encoding (IDLE=2'd0, WRITEBACK=2'd1, FETCH=2'd2);
  - ADDR_W = 8, BLOCK_W = 32, OFFSET_W = 2;
  - field-extraction helper functions.
- Sub-module dcache_array: the valid/dirty/tag/data storage.
  - Async clear of valid/dirty.
  - Byte-write and block-install ports.
  - Combinational read of the indexed line.
- The FSM and hit logic stay in dcache_controller.

Test Plan:
- Cold read: reset, memory block 0x01 = 0x44332211 (4-cycle latency), READ addr 0x05 -> BUSYWAIT high, MEM_READ with MEM_ADDRESS = 0x01; after install READDATA = 0x22, BUSYWAIT falls; MEM_WRITE never asserted.
- Read hit: READ addr 0x07 after the cold read -> READDATA = 0x44, BUSYWAIT low in the same cycle, no memory request.
- Store hit: WRITE 0xAB to 0x05 -> no stall; a following READ 0x05 returns 0xAB; line 1 dirty.
- Dirty eviction:
  - READ 0x25 -> MEM_WRITE, MEM_ADDRESS = 0x01, MEM_WRITEDATA = 0x4433AB11.
  - Then MEM_READ, MEM_ADDRESS = 0x09.
  - Then READDATA = byte 1 of memory block 0x09.
- Write miss: WRITE 0x5A to 0x80 on an invalid line -> FETCH of MEM_ADDRESS = 0x20, then byte written, line dirty, READ 0x80 returns 0x5A.
- Reset mid-FETCH: pull RESET low during the FETCH latency -> MEM_READ drops immediately, BUSYWAIT = 0; a later READ 0x05 misses again (line invalid).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM encoding, fixed widths and address/block field helpers.
package dcache_pkg;

    localparam int ADDR_W   = 8;
    localparam int BLOCK_W  = 32;
    localparam int OFFSET_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_e;

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

    function automatic logic [ADDR_W-OFFSET_W-1:0] addr_block(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_W];
    endfunction

    // Byte k of a block lives at bits [8k+7:8k].
    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFFSET_W-1:0] off);
        return blk[{off, 3'b000} +: 8];
    endfunction

    function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                    input logic [OFFSET_W-1:0] off,
                                                    input logic [7:0]          data);
        logic [BLOCK_W-1:0] res;
        res = blk;
        res[{off, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid/dirty bits (async cleared),
// tag and data arrays, with a byte-write port and a block-install port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 6 - INDEX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  idx,
    input  logic                byte_we,
    input  logic [OFFSET_W-1:0] byte_off,
    input  logic [7:0]          byte_data,
    input  logic                fill_we,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data,
    output logic                valid_o,
    output logic                dirty_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [BLOCK_W-1:0]  data_o
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];
    logic [BLOCK_W-1:0] data_d [LINES];

    // Next-state of the indexed line; an install takes priority over a byte write.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case ({fill_we, byte_we})
            2'b10, 2'b11: begin
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                tag_d[idx]   = fill_tag;
                data_d[idx]  = fill_data;
            end
            2'b01: begin
                dirty_d[idx] = 1'b1;
                data_d[idx]  = put_byte(data_q[idx], byte_off, byte_data);
            end
            default: ;
        endcase
    end

    // Status bits: cleared asynchronously so every line is invalid out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data payload: meaningless while the valid bit is clear, so not reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign valid_o = valid_q[idx];
    assign dirty_o = dirty_q[idx];
    assign tag_o   = tag_q[idx];
    assign data_o  = data_q[idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller: hit logic,
// IDLE/WRITEBACK/FETCH miss FSM and the block-wide memory interface.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int TAG_W = 6 - INDEX_W;

    state_e state_q, state_d;

    logic [TAG_W-1:0]    tag_s;
    logic [INDEX_W-1:0]  index_s;
    logic [OFFSET_W-1:0] offset_s;
    logic                req_s;
    logic                hit_s;
    logic                idle_hit_s;
    logic                line_valid_s;
    logic                line_dirty_s;
    logic [TAG_W-1:0]    line_tag_s;
    logic [BLOCK_W-1:0]  line_data_s;
    logic                byte_we_s;
    logic                fill_we_s;

    assign tag_s      = ADDRESS[ADDR_W-1:OFFSET_W+INDEX_W];
    assign index_s    = ADDRESS[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign offset_s   = addr_offset(ADDRESS);
    assign req_s      = READ | WRITE;
    assign hit_s      = line_valid_s & (line_tag_s == tag_s);
    assign idle_hit_s = (state_q == IDLE) & hit_s;

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (CLK),
        .rst_n     (RESET),
        .idx       (index_s),
        .byte_we   (byte_we_s),
        .byte_off  (offset_s),
        .byte_data (WRITEDATA),
        .fill_we   (fill_we_s),
        .fill_tag  (tag_s),
        .fill_data (MEM_READDATA),
        .valid_o   (line_valid_s),
        .dirty_o   (line_dirty_s),
        .tag_o     (line_tag_s),
        .data_o    (line_data_s)
    );

    // Miss FSM next state plus memory-side outputs decoded from the current state.
    always_comb begin
        state_d       = state_q;
        byte_we_s     = 1'b0;
        fill_we_s     = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'd0;
        MEM_WRITEDATA = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_s && !hit_s) begin
                    state_d = (line_valid_s && line_dirty_s) ? WRITEBACK : FETCH;
                end else begin
                    // READ wins when both are raised, so a store needs WRITE alone.
                    byte_we_s = WRITE & ~READ & hit_s;
                end
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {line_tag_s, index_s};
                MEM_WRITEDATA = line_data_s;
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = addr_block(ADDRESS);
                if (!MEM_BUSYWAIT) begin
                    fill_we_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CPU-side outputs are forced quiet while reset is held, even if READ/WRITE linger.
    assign BUSYWAIT = RESET & req_s & ~idle_hit_s;
    assign READDATA = (RESET && READ && idle_hit_s) ? get_byte(line_data_s, offset_s) : 8'd0;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed table-driven bench for dcache_controller with a 4-cycle block memory model.
module tb_dcache_controller;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int total = 0;
    int bad   = 0;

    dcache_controller #(.INDEX_W(3)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: busy from the cycle a request rises until 4 posedges have passed.
    logic [31:0] mem [64];
    logic [2:0]  mem_cnt;
    logic        mem_loaded = 1'b0;

    function automatic logic [31:0] init_blk(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 1) return 32'h44332211;
        return {b, b + 8'h40, b + 8'h80, b + 8'hC0};
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_cnt <= 3'd0;
            if (!mem_loaded) begin
                for (int i = 0; i < 64; i++) mem[i] <= init_blk(i);
                mem_loaded <= 1'b1;
            end
        end else if (MEM_READ || MEM_WRITE) begin
            if (mem_cnt == 3'd4) begin
                mem_cnt <= 3'd0;
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            end else begin
                mem_cnt <= mem_cnt + 3'd1;
            end
        end else begin
            mem_cnt <= 3'd0;
        end
    end

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt != 3'd4);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        int          exp_stall;
        logic        exp_mr;
        logic        exp_mw;
        logic [5:0]  exp_fa;
        logic [5:0]  exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [15];

    // Apply one CPU request, hold it until BUSYWAIT drops, then check what was seen.
    task automatic access(input int n);
        vec_t        v;
        int          stall;
        logic        mr, mw, both, done;
        logic [5:0]  fa, wa;
        logic [31:0] wd;
        logic [7:0]  rdata;
        v = vecs[n];
        stall = 0; mr = 1'b0; mw = 1'b0; both = 1'b0; done = 1'b0;
        fa = 6'd0; wa = 6'd0; wd = 32'd0; rdata = 8'd0;
        READ = v.rd; WRITE = v.wr; ADDRESS = v.addr; WRITEDATA = v.wdata;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (MEM_READ) begin
                if (!mr) fa = MEM_ADDRESS;
                mr = 1'b1;
            end
            if (MEM_WRITE) begin
                if (!mw) begin
                    wa = MEM_ADDRESS;
                    wd = MEM_WRITEDATA;
                end
                mw = 1'b1;
            end
            if (MEM_READ && MEM_WRITE) both = 1'b1;
            if (!BUSYWAIT) begin
                done  = 1'b1;
                rdata = READDATA;
                break;
            end
            stall++;
        end
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
        chk($sformatf("v%0d done", n), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d stall", n), 32'(stall), 32'(v.exp_stall));
        chk($sformatf("v%0d mem_read", n), {31'd0, mr}, {31'd0, v.exp_mr});
        chk($sformatf("v%0d mem_write", n), {31'd0, mw}, {31'd0, v.exp_mw});
        chk($sformatf("v%0d rd_wr_excl", n), {31'd0, both}, 32'd0);
        if (v.rd) chk($sformatf("v%0d readdata", n), {24'd0, rdata}, {24'd0, v.exp_rdata});
        if (v.exp_mr) chk($sformatf("v%0d fetch_addr", n), {26'd0, fa}, {26'd0, v.exp_fa});
        if (v.exp_mw) begin
            chk($sformatf("v%0d wb_addr", n), {26'd0, wa}, {26'd0, v.exp_wa});
            chk($sformatf("v%0d wb_data", n), wd, v.exp_wd);
        end
    endtask

    initial begin
        //                rd    wr    addr   wdata  rdata  stall mr    mw    fetch  wbaddr wbdata
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 6,  1'b1, 1'b0, 6'h01, 6'h00, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 8'h07, 8'h00, 8'h44, 0,  1'b0, 1'b0, 6'h00, 6'h00, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 8'h05, 8'hAB, 8'h00, 0,  1'b0, 1'b0, 6'h00, 6'h00, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hAB, 0,  1'b0, 1'b0, 6'h00, 6'h00, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 8'h04, 8'h00, 8'h11, 0,  1'b0, 1'b0, 6'h00, 6'h00, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 8'h25, 8'h00, 8'h89, 11, 1'b1, 1'b1, 6'h09, 6'h01, 32'h4433AB11};
        vecs[6]  = '{1'b0, 1'b1, 8'h80, 8'h5A, 8'h00, 6,  1'b1, 1'b0, 6'h20, 6'h00, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h5A, 0,  1'b0, 1'b0, 6'h00, 6'h00, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 8'h83, 8'h00, 8'h20, 0,  1'b0, 1'b0, 6'h00, 6'h00, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hAB, 6,  1'b1, 1'b0, 6'h01, 6'h00, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hC0, 11, 1'b1, 1'b1, 6'h00, 6'h20, 32'h2060A05A};
        vecs[11] = '{1'b1, 1'b1, 8'h01, 8'hFF, 8'h80, 0,  1'b0, 1'b0, 6'h00, 6'h00, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h80, 0,  1'b0, 1'b0, 6'h00, 6'h00, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 8'h81, 8'h00, 8'hA0, 6,  1'b1, 1'b0, 6'h20, 6'h00, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hAB, 6,  1'b1, 1'b0, 6'h01, 6'h00, 32'h0};

        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("rst readdata", {24'd0, READDATA}, 32'd0);
        chk("rst mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("rst mem_write", {31'd0, MEM_WRITE}, 32'd0);
        chk("rst mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
        chk("rst mem_writedata", MEM_WRITEDATA, 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 14; i++) access(i);

        // Reset in the middle of a line fetch for 0x45 (index 1 holds a clean line).
        READ = 1'b1; ADDRESS = 8'h45;
        repeat (3) @(posedge CLK);
        #2;
        chk("midrst pre mem_read", {31'd0, MEM_READ}, 32'd1);
        chk("midrst pre mem_addr", {26'd0, MEM_ADDRESS}, 32'h11);
        RESET = 1'b0;
        #1;
        chk("midrst mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("midrst mem_write", {31'd0, MEM_WRITE}, 32'd0);
        chk("midrst busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("midrst readdata", {24'd0, READDATA}, 32'd0);
        chk("midrst mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
        READ = 1'b0;
        #3;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        access(14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
